// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a registered borrow,
// processing a - b - bin LSB first, one bit per clock, behind a start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_shift;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg;
  logic             ai, bi, d, br_next, last;

  assign ai      = a_reg[0];
  assign bi      = b_reg[0];
  assign d       = ai ^ bi ^ br_reg;
  assign br_next = (~ai & bi) | (~(ai ^ bi) & br_reg);
  assign last    = (cnt_reg == LAST);

  // New difference bit enters at the MSB so the LSB-first stream lands in place.
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_shift = d;
    end else begin : g_wn
      assign res_shift = {d, res_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Published outputs are written only on the final bit so partial results never show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      cnt_reg <= '0;
      br_reg  <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            br_reg  <= bin;
            cnt_reg <= '0;
          end
        end
        RUN: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          br_reg  <= br_next;
          res_reg <= res_shift;
          if (last) begin
            diff <= res_shift;
            bout <= br_next;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 8, 3 and 1: vector table,
// handshake/reset sequences, randomized and exhaustive runs against an arithmetic model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 0, bin8 = 0, busy8, done8, bout8;
  logic [7:0] a8 = 0, b8 = 0, diff8;
  logic       start3 = 0, bin3 = 0, busy3, done3, bout3;
  logic [2:0] a3 = 0, b3 = 0, diff3;
  logic       start1 = 0, bin1 = 0, busy1, done1, bout1;
  logic [0:0] a1 = 0, b1 = 0, diff1;

  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .bin(bin8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));
  serial_subtractor #(.WIDTH(3)) u3 (.clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .bin(bin3), .busy(busy3), .done(done3), .diff(diff3), .bout(bout3));
  serial_subtractor #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .bin(bin1), .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));

  int nvec = 0;
  int nmis = 0;
  int dc8 = 0;

  always @(negedge clk) if (done8) dc8 <= dc8 + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_d;
    logic       exp_bo;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit values.
  function automatic logic [8:0] model(input int w, input int av, input int bv, input int bi);
    int m, r;
    m = (1 << w) - 1;
    r = (av & m) - (bv & m) - bi;
    return {(r < 0) ? 1'b1 : 1'b0, 8'(r & m)};
  endfunction

  function automatic logic [7:0] rd_diff(input int w);
    case (w)
      8: return diff8;
      3: return {5'd0, diff3};
      default: return {7'd0, diff1};
    endcase
  endfunction
  function automatic logic rd_bout(input int w);
    return (w == 8) ? bout8 : (w == 3) ? bout3 : bout1;
  endfunction
  function automatic logic rd_done(input int w);
    return (w == 8) ? done8 : (w == 3) ? done3 : done1;
  endfunction
  function automatic logic rd_busy(input int w);
    return (w == 8) ? busy8 : (w == 3) ? busy3 : busy1;
  endfunction

  task automatic drive(input int w, input logic s, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi);
    case (w)
      8: begin start8 = s; a8 = av; b8 = bv; bin8 = bi; end
      3: begin start3 = s; a3 = av[2:0]; b3 = bv[2:0]; bin3 = bi; end
      default: begin start1 = s; a1 = av[0:0]; b1 = bv[0:0]; bin1 = bi; end
    endcase
  endtask

  // One transaction: load, scramble inputs, wait for done, check result, latency, hold, pulse width.
  task automatic run_check(input int w, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                           input string nm);
    logic [7:0] pd;
    logic       pb, held, got;
    logic [8:0] exp;
    int         lat, busyc;
    @(negedge clk);
    pd = rd_diff(w);
    pb = rd_bout(w);
    drive(w, 1'b1, av, bv, bi);
    @(posedge clk);
    #1 drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    lat = 0; busyc = 0; held = 1'b1; got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rd_done(w)) begin got = 1'b1; break; end
      if (rd_busy(w)) busyc++;
      if (rd_diff(w) !== pd || rd_bout(w) !== pb) held = 1'b0;
      lat++;
    end
    exp = model(w, int'(av), int'(bv), int'(bi));
    $display("txn %s w=%0d a=%0h b=%0h bin=%0d -> diff=%0h bout=%0d lat=%0d", nm, w, av, bv, bi,
             rd_diff(w), rd_bout(w), lat);
    chk({nm, " done_seen"}, 32'(got), 32'd1);
    chk({nm, " diff"}, 32'(rd_diff(w)), 32'(exp[7:0]));
    chk({nm, " bout"}, 32'(rd_bout(w)), 32'(exp[8]));
    chk({nm, " latency"}, 32'(lat), 32'(w));
    if (w == 8) begin
      chk({nm, " busy_cycles"}, 32'(busyc), 32'd8);
      chk({nm, " hold_prev"}, 32'(held), 32'd1);
    end
    @(negedge clk);
    chk({nm, " done_width"}, 32'(rd_done(w)), 32'd0);
  endtask

  int         rises[$];
  int         dsnap;
  logic       prevb;
  logic [8:0] e;

  initial begin
    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    tbl[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset diff", 32'(diff8), 32'd0);
    chk("reset bout", 32'(bout8), 32'd0);

    // Vector table: the model is also checked against hand-derived expectations.
    for (int i = 0; i < 6; i++) begin
      e = model(8, int'(tbl[i].a), int'(tbl[i].b), int'(tbl[i].bin));
      chk($sformatf("tbl%0d model", i), 32'(e), 32'({tbl[i].exp_bo, tbl[i].exp_d}));
      run_check(8, tbl[i].a, tbl[i].b, tbl[i].bin, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d diff_tbl", i), 32'(diff8), 32'(tbl[i].exp_d));
      chk($sformatf("tbl%0d bout_tbl", i), 32'(bout8), 32'(tbl[i].exp_bo));
    end

    // Asynchronous reset with no clock edge: outputs clear immediately.
    run_check(8, 8'h5A, 8'h3C, 1'b0, "pre_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst diff", 32'(diff8), 32'd0);
    chk("async_rst busy", 32'(busy8), 32'd0);
    chk("async_rst done", 32'(done8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dsnap = dc8;
    repeat (12) @(negedge clk);
    chk("after_rst no_done", 32'(dc8 - dsnap), 32'd0);
    chk("after_rst diff", 32'(diff8), 32'd0);

    // start pulsed during RUN is ignored.
    dsnap = dc8;
    @(negedge clk);
    drive(8, 1'b1, 8'h80, 8'h01, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 8'h80, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    drive(8, 1'b1, 8'h00, 8'hFF, 1'b1);
    @(negedge clk);
    drive(8, 1'b0, 8'h00, 8'hFF, 1'b1);
    repeat (15) @(negedge clk);
    $display("txn handshake a=80 b=01 -> diff=%0h bout=%0d dones=%0d", diff8, bout8, dc8 - dsnap);
    chk("hs diff", 32'(diff8), 32'h7F);
    chk("hs bout", 32'(bout8), 32'd0);
    chk("hs one_done", 32'(dc8 - dsnap), 32'd1);

    // start held high: loads every WIDTH+2 clocks.
    dsnap = dc8;
    prevb = 1'b0;
    @(negedge clk);
    drive(8, 1'b1, 8'h37, 8'h12, 1'b0);
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (busy8 && !prevb) rises.push_back(i);
      prevb = busy8;
    end
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (10) @(negedge clk);
    $display("txn hold_start loads=%0d dones=%0d diff=%0h", rises.size(), dc8 - dsnap, diff8);
    chk("hold loads", 32'(rises.size()), 32'd4);
    if (rises.size() >= 3) begin
      chk("hold spacing1", 32'(rises[1] - rises[0]), 32'd10);
      chk("hold spacing2", 32'(rises[2] - rises[1]), 32'd10);
    end
    chk("hold dones", 32'(dc8 - dsnap), 32'(rises.size()));
    chk("hold diff", 32'(diff8), 32'h25);

    // Reset mid-RUN aborts the operation without a done.
    dsnap = dc8;
    @(negedge clk);
    drive(8, 1'b1, 8'hAA, 8'h55, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("midrst busy_before", 32'(busy8), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy8), 32'd0);
    chk("midrst diff", 32'(diff8), 32'd0);
    chk("midrst bout", 32'(bout8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst no_done", 32'(dc8 - dsnap), 32'd0);
    run_check(8, 8'h03, 8'h05, 1'b0, "post_rst");

    for (int i = 0; i < 20; i++)
      run_check(8, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", i));

    for (int i = 0; i < 128; i++)
      run_check(3, 8'(i & 7), 8'((i >> 3) & 7), 1'(i >> 6), $sformatf("w3_%0d", i));

    for (int i = 0; i < 8; i++)
      run_check(1, 8'(i & 1), 8'((i >> 1) & 1), 1'(i >> 2), $sformatf("w1_%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
